// File: rtl/fault_chk_pkg.sv
// Shared definitions for the fault response checker.
//   - state_e    : campaign FSM states (also exported on the debug state port)
//   - det_rec_t  : layout of one detection record {fault_id, vector} at the
//                  default widths; the top packs records in this same order
//   - *_DEF      : default parameter values
package fault_chk_pkg;

  localparam int VEC_W_DEF = 6;
  localparam int FID_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [FID_W_DEF-1:0] fault_id;
    logic [VEC_W_DEF-1:0] vector;
  } det_rec_t;

endpackage

// File: rtl/fault_response_checker_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write request / data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata           head entry, valid whenever !empty; forced to 0 when empty
//   full, empty     occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; the empty gate below keeps stale data off rdata.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fault_response_checker.sv
// fault_response_checker: compares golden vs faulty responses for a fault
// simulation campaign, records the first detecting vector of each fault and
// counts completed / detected faults.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           pulse: begin campaign (IDLE/DONE only)
//   in_valid/in_ready               response beat handshake
//   in_fault_id, in_vector          identity of the beat
//   in_good, in_faulty              golden / faulty circuit outputs
//   in_last_vec, in_last_fault      end-of-fault / end-of-campaign markers
//   det_valid/det_ready             detection record handshake (FWFT FIFO)
//   det_fault_id, det_vector        head detection record
//   fault_count, detect_count       saturating campaign counters
//   busy, done                      RUN|DROP / DONE status
//   dbg_state                       current FSM state (state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends on valid, and data is ignored otherwise.
module fault_response_checker
  import fault_chk_pkg::*;
#(
  parameter int VEC_W = VEC_W_DEF,
  parameter int FID_W = FID_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FID_W-1:0] in_fault_id,
  input  logic [VEC_W-1:0] in_vector,
  input  logic             in_good,
  input  logic             in_faulty,
  input  logic             in_last_vec,
  input  logic             in_last_fault,
  output logic             det_valid,
  input  logic             det_ready,
  output logic [FID_W-1:0] det_fault_id,
  output logic [VEC_W-1:0] det_vector,
  output logic [CNT_W-1:0] fault_count,
  output logic [CNT_W-1:0] detect_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int REC_W = FID_W + VEC_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;

  logic             accept;
  logic             mismatch;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_rdata;

  assign accept   = in_valid && in_ready;
  assign mismatch = in_good ^ in_faulty;
  // Only the first mismatch of a fault is recorded; DROP swallows the rest.
  assign push     = (state_q == ST_RUN) && accept && mismatch;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_RUN:  in_ready = !fifo_full;
      ST_DROP: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fault_cnt_d = fault_cnt_q;
    det_cnt_d   = det_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          fault_cnt_d = '0;
          det_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (mismatch) begin
            det_cnt_d = (det_cnt_q == '1) ? det_cnt_q : det_cnt_q + 1'b1;
            // A detection on the last vector completes the fault directly.
            if (!in_last_vec) state_d = ST_DROP;
          end
          if (in_last_vec) begin
            fault_cnt_d = (fault_cnt_q == '1) ? fault_cnt_q : fault_cnt_q + 1'b1;
            state_d     = in_last_fault ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_DROP: begin
        if (accept && in_last_vec) begin
          fault_cnt_d = (fault_cnt_q == '1) ? fault_cnt_q : fault_cnt_q + 1'b1;
          state_d     = in_last_fault ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fault_cnt_q <= '0;
      det_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fault_cnt_q <= fault_cnt_d;
      det_cnt_q   <= det_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_fault_id, in_vector}),
    .pop   (det_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign det_valid    = !fifo_empty;
  assign det_fault_id = fifo_rdata[VEC_W +: FID_W];
  assign det_vector   = fifo_rdata[VEC_W-1:0];
  assign fault_count  = fault_cnt_q;
  assign detect_count = det_cnt_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DROP);
  assign done         = (state_q == ST_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fault_response_checker.sv
module tb_fault_response_checker;
  import fault_chk_pkg::*;

  localparam int VW = 6;
  localparam int FW = 8;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int RW = FW + VW;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_fault_id = '0;
  logic [VW-1:0] in_vector = '0;
  logic          in_good = 1'b0;
  logic          in_faulty = 1'b0;
  logic          in_last_vec = 1'b0;
  logic          in_last_fault = 1'b0;
  logic          det_ready = 1'b1;

  logic          in_ready, det_valid, busy, done;
  logic [FW-1:0] det_fault_id;
  logic [VW-1:0] det_vector;
  logic [CW-1:0] fault_count, detect_count;
  logic [1:0]    dbg_state;

  logic          b_in_ready, b_det_valid, b_busy, b_done;
  logic [FW-1:0] b_det_fault_id;
  logic [VW-1:0] b_det_vector;
  logic [SW-1:0] b_fault_count, b_detect_count;
  logic [1:0]    b_dbg_state;

  always #5 clk = ~clk;

  fault_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fault_id(in_fault_id), .in_vector(in_vector), .in_good(in_good), .in_faulty(in_faulty),
    .in_last_vec(in_last_vec), .in_last_fault(in_last_fault), .det_valid(det_valid),
    .det_ready(det_ready), .det_fault_id(det_fault_id), .det_vector(det_vector),
    .fault_count(fault_count), .detect_count(detect_count), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  fault_response_checker #(.CNT_W(SW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fault_id(in_fault_id), .in_vector(in_vector), .in_good(in_good), .in_faulty(in_faulty),
    .in_last_vec(in_last_vec), .in_last_fault(in_last_fault), .det_valid(b_det_valid),
    .det_ready(det_ready), .det_fault_id(b_det_fault_id), .det_vector(b_det_vector),
    .fault_count(b_fault_count), .detect_count(b_detect_count), .busy(b_busy), .done(b_done),
    .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [RW-1:0] exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  m_det = 0;
  int  m_fault = 0;
  bit  m_drop = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_det = 0; m_fault = 0; m_drop = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      // Junk on the data lines must be ignored while in_valid is low.
      in_fault_id = FW'($urandom_range(0, 255));
      in_vector   = VW'($urandom_range(0, 63));
      in_good     = 1'b0;
      in_faulty   = 1'b1;
      in_last_vec = 1'b1;
      in_last_fault = 1'b1;
      @(negedge clk);
    end
    in_last_vec = 1'b0; in_last_fault = 1'b0;
  endtask

  // Presents one beat at a negedge, waits for acceptance, returns at the
  // negedge after the accepting edge with in_valid still high.
  task automatic send_beat(input logic [FW-1:0] fid, input logic [VW-1:0] vec,
                           input bit mism, input bit lv, input bit lf);
    int t;
    in_fault_id   = fid;
    in_vector     = vec;
    in_good       = 1'($urandom_range(0, 1));
    in_faulty     = in_good ^ mism;
    in_last_vec   = lv;
    in_last_fault = lf;
    in_valid      = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b for fault %0d, required 1 within 200 cycles", in_ready, fid);
      in_valid = 1'b0;
      return;
    end
    if (!m_drop && mism) begin
      exp_q.push_back({fid, vec});
      m_det++;
      if (!lv) m_drop = 1'b1;
    end
    if (lv) begin
      m_fault++;
      m_drop = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  // Compares every popped detection record against the expected queue.
  task automatic monitor();
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && det_valid === 1'b1 && det_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got id=%0d vec=%0d, required no record", det_fault_id, det_vector);
        end else begin
          e = exp_q.pop_front();
          if ({det_fault_id, det_vector} !== e) begin
            n_err++;
            $display("FAIL record: got id=%0d vec=%0d, required id=%0d vec=%0d",
                     det_fault_id, det_vector, e[RW-1:VW], e[VW-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    n_vec++; if (det_valid !== 1'b0) begin n_err++; $display("FAIL rst_det_valid: got %b, required 0", det_valid); end
    n_vec++; if (fault_count !== '0 || detect_count !== '0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d, required 0/0", fault_count, detect_count); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_status: got busy=%b done=%b, required 0/0", busy, done); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    n_vec++; if (det_fault_id !== '0 || det_vector !== '0) begin n_err++; $display("FAIL rst_det_data: got %0d/%0d, required 0/0", det_fault_id, det_vector); end
    rst_n = 1'b1;
    in_valid = 1'b1; in_good = 1'b0; in_faulty = 1'b1; in_last_vec = 1'b1; in_last_fault = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (dbg_state !== ST_IDLE || in_ready !== 1'b0) begin n_err++; $display("FAIL no_start_idle: got state=%0d in_ready=%b, required %0d/0", dbg_state, in_ready, ST_IDLE); end
    n_vec++; if (detect_count !== '0 || det_valid !== 1'b0) begin n_err++; $display("FAIL no_start_counts: got dc=%0d det_valid=%b, required 0/0", detect_count, det_valid); end
    idle(1);
  endtask

  task automatic test_single_detect();
    det_ready = 1'b1;
    do_start();
    n_vec++; if (dbg_state !== ST_RUN || busy !== 1'b1) begin n_err++; $display("FAIL start_run: got state=%0d busy=%b, required %0d/1", dbg_state, busy, ST_RUN); end
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < 4; v++) begin
        send_beat(FW'(f), VW'($urandom_range(0, 63)), (f == 1 && v == 2), (v == 3), (f == 2));
        if (f == 1 && v == 2) begin
          n_vec++; if (det_valid !== 1'b1) begin n_err++; $display("FAIL det_latency: got det_valid=%b, required 1", det_valid); end
          n_vec++; if (dbg_state !== ST_DROP) begin n_err++; $display("FAIL enter_drop: got %0d, required %0d", dbg_state, ST_DROP); end
        end
      end
      if (f == 0) idle(2);
    end
    idle(1);
    n_vec++; if (done !== 1'b1 || dbg_state !== ST_DONE) begin n_err++; $display("FAIL single_done: got done=%b state=%0d, required 1/%0d", done, dbg_state, ST_DONE); end
    n_vec++; if (fault_count !== 16'd3) begin n_err++; $display("FAIL single_fc: got %0d, required 3", fault_count); end
    n_vec++; if (detect_count !== 16'd1) begin n_err++; $display("FAIL single_dc: got %0d, required 1", detect_count); end
    wait_drain();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_drop();
    do_start();
    n_vec++; if (fault_count !== '0 || detect_count !== '0) begin n_err++; $display("FAIL restart_clear: got %0d/%0d, required 0/0", fault_count, detect_count); end
    send_beat(8'd5, VW'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b1);
    idle(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (dbg_state !== ST_DROP || detect_count !== 16'd1) begin n_err++; $display("FAIL start_in_drop: got state=%0d dc=%0d, required %0d/1", dbg_state, detect_count, ST_DROP); end
    send_beat(8'd5, VW'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b1);
    send_beat(8'd5, VW'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b1);
    send_beat(8'd5, VW'($urandom_range(0, 63)), 1'b1, 1'b1, 1'b1);
    idle(1);
    n_vec++; if (detect_count !== 16'd1 || fault_count !== 16'd1) begin n_err++; $display("FAIL drop_counts: got dc=%0d fc=%0d, required 1/1", detect_count, fault_count); end
    n_vec++; if (dbg_state !== ST_DONE) begin n_err++; $display("FAIL drop_done: got %0d, required %0d", dbg_state, ST_DONE); end
    wait_drain();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    det_ready = 1'b0;
    do_start();
    for (int f = 0; f < 4; f++) begin
      send_beat(FW'(8'h10 + f), VW'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0);
      send_beat(FW'(8'h10 + f), VW'($urandom_range(0, 63)), 1'b0, 1'b1, 1'b0);
    end
    idle(3);
    n_vec++; if (in_ready !== 1'b0 || dbg_state !== ST_RUN) begin n_err++; $display("FAIL full_stall: got in_ready=%b state=%0d, required 0/%0d", in_ready, dbg_state, ST_RUN); end
    n_vec++; if (detect_count !== 16'd4 || det_valid !== 1'b1) begin n_err++; $display("FAIL full_dc: got dc=%0d det_valid=%b, required 4/1", detect_count, det_valid); end
    det_ready = 1'b1;
    send_beat(8'h14, VW'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b1);
    send_beat(8'h14, VW'($urandom_range(0, 63)), 1'b0, 1'b1, 1'b1);
    idle(1);
    n_vec++; if (detect_count !== 16'd5 || fault_count !== 16'd5) begin n_err++; $display("FAIL bp_counts: got dc=%0d fc=%0d, required 5/5", detect_count, fault_count); end
    wait_drain();
    n_vec++; if (exp_q.size() != 0 || det_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0d pending det_valid=%b, required 0/0", exp_q.size(), det_valid); end
  endtask

  task automatic test_back_to_back();
    det_ready = 1'b1;
    do_start();
    for (int f = 0; f < 6; f++)
      send_beat(FW'(8'h20 + f), VW'($urandom_range(0, 63)), 1'b1, 1'b1, (f == 5));
    n_vec++; if (dbg_state !== ST_DONE) begin n_err++; $display("FAIL last_detect_done: got %0d, required %0d", dbg_state, ST_DONE); end
    n_vec++; if (fault_count !== 16'd6 || detect_count !== 16'd6) begin n_err++; $display("FAIL b2b_counts: got fc=%0d dc=%0d, required 6/6", fault_count, detect_count); end
    idle(1);
    wait_drain();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    det_ready = 1'b0;
    do_start();
    send_beat(8'h30, VW'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0);
    send_beat(8'h30, VW'($urandom_range(0, 63)), 1'b0, 1'b1, 1'b0);
    send_beat(8'h31, VW'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0);
    idle(1);
    n_vec++; if (dbg_state !== ST_DROP || det_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset: got state=%0d det_valid=%b, required %0d/1", dbg_state, det_valid, ST_DROP); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (det_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL async_rst_hs: got det_valid=%b in_ready=%b, required 0/0", det_valid, in_ready); end
    n_vec++; if (fault_count !== '0 || detect_count !== '0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL async_rst_state: got fc=%0d dc=%0d state=%0d, required 0/0/%0d", fault_count, detect_count, dbg_state, ST_IDLE); end
    n_vec++; if (busy !== 1'b0 || det_fault_id !== '0 || det_vector !== '0) begin n_err++; $display("FAIL async_rst_out: got busy=%b id=%0d vec=%0d, required 0/0/0", busy, det_fault_id, det_vector); end
    exp_q.delete();
    m_det = 0; m_fault = 0; m_drop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    det_ready = 1'b1;
    idle(3);
    n_vec++; if (dbg_state !== ST_IDLE || det_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got state=%0d det_valid=%b, required %0d/0", dbg_state, det_valid, ST_IDLE); end
    do_start();
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 3; v++)
        send_beat(FW'(8'h40 + f), VW'($urandom_range(0, 63)), (f == 1 && v == 1), (v == 2), (f == 1));
    idle(1);
    n_vec++; if (detect_count !== 16'd1 || fault_count !== 16'd2 || done !== 1'b1) begin n_err++; $display("FAIL clean_run: got dc=%0d fc=%0d done=%b, required 1/2/1", detect_count, fault_count, done); end
    wait_drain();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL clean_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    det_ready = 1'b1;
    do_start();
    for (int f = 0; f < 17; f++)
      send_beat(FW'(8'h50 + f), VW'($urandom_range(0, 63)), 1'b1, 1'b1, (f == 16));
    idle(1);
    n_vec++; if (b_detect_count !== 4'd15) begin n_err++; $display("FAIL sat_dc: got %0d, required 15", b_detect_count); end
    n_vec++; if (b_fault_count !== 4'd15) begin n_err++; $display("FAIL sat_fc: got %0d, required 15", b_fault_count); end
    n_vec++; if (detect_count !== 16'(m_det) || fault_count !== 16'd17) begin n_err++; $display("FAIL wide_counts: got dc=%0d fc=%0d, required %0d/17", detect_count, fault_count, m_det); end
    wait_drain();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sat_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_detect();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
